eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single byte-wide AXI-stream TX port of the Ethernet MAC/PHY wrapper between N_PORTS independent frame sources, e.g. per-UDP-port transmit engines.
- A granted source owns the output until its tlast beat completes.
- A length watchdog truncates runaway frames so one faulty source cannot hold the link indefinitely.

Parameters:
- N_PORTS, 2, number of requesting sources, 2..8.
- MAX_FRAME_BYTES, 1518, maximum beats forwarded per frame before forced truncation, 2..65535.

Ports:
- i_clock  input  1  system clock (MAC user-side clock domain)
- i_reset  input  1  synchronous active-high reset
- i_s_valid  input  N_PORTS  per-source tvalid
- i_s_data  input  8*N_PORTS  per-source tdata; source k occupies bits [8k+7:8k]
- i_s_last  input  N_PORTS  per-source tlast
- i_s_user  input  N_PORTS  per-source tuser (frame error)
- o_s_ready  output  N_PORTS  per-source tready
- o_m_valid  output  1  to MAC io_tx_valid
- o_m_data  output  8  to MAC io_tx_bits_tdata
- o_m_last  output  1  to MAC io_tx_bits_tlast
- o_m_user  output  1  to MAC io_tx_bits_tuser
- i_m_ready  input  1  from MAC io_tx_ready
- o_grant  output  N_PORTS  one-hot current owner; zero when idle
- o_trunc_count  output  16  saturating count of truncated frames

Behaviour:
- Reset: clock i_clock; reset i_reset, synchronous, active-high. State returns to IDLE, o_grant=0, last-winner pointer=N_PORTS-1 (so port 0 wins first), beat counter=0, o_trunc_count=0. All o_s_ready=0 and o_m_valid=0 in the cycle after reset is sampled. Reset mid-frame abandons the frame immediately, with no tlast emitted.
- IDLE:
  - o_m_valid=0, all o_s_ready=0.
  - If any i_s_valid is high, select the first valid port searching (last_winner+1) mod N_PORTS upward with wrap.
  - Register o_grant, update last_winner, clear beat counter, go to PASS.
  - Arbitration costs exactly one bubble cycle per frame.
- PASS (combinational passthrough from granted port g):
  - o_m_valid=i_s_valid[g], o_m_data=data[g], o_s_ready[g]=i_m_ready; other readies 0.
  - A beat transfers when o_m_valid and i_m_ready are both high; the beat counter increments on each transfer.
  - Normal beat: o_m_last=i_s_last[g], o_m_user=i_s_user[g].
  - Transfer with i_s_last[g]=1: go to IDLE next cycle, o_grant=0.
  - Watchdog: when the counter equals MAX_FRAME_BYTES-1 and the current beat has i_s_last[g]=0, force o_m_last=1 and o_m_user=1 on that beat.
    - On transfer, increment o_trunc_count, saturating at 0xFFFF.
    - Go to DROP.
  - A source deasserting valid mid-frame stalls the output (o_m_valid=0); the grant is held and no timeout applies.
- DROP:
  - o_m_valid=0, o_s_ready[g]=1; all other readies 0.
  - Discard beats from g until a beat with i_s_last[g]=1 is accepted, then go to IDLE.
- Ordering and fairness:
  - Frames are never interleaved.
  - With all ports continuously requesting, grants rotate 0,1,…,N-1,0.
  - A port that is the sole requester may win consecutive frames.
- Boundaries:
  - A 1-beat frame (valid+last on the first beat) is legal: PASS for one transfer, then IDLE.
  - A frame of exactly MAX_FRAME_BYTES with last on the final beat is not truncated.
  - The counter is 16 bits and cannot wrap, since MAX_FRAME_BYTES ≤ 65535.
  - i_m_ready low holds all state, data is not consumed, and the watchdog does not advance.

Test Plan:
- Single source, port 1 sends a 64-byte frame with i_m_ready=1 -> 1 idle cycle, then 64 consecutive output beats matching the input, o_m_last on beat 64, o_grant=2'b10 throughout, o_trunc_count=0.
- Ports 0 and 1 both hold back-to-back 10-byte frames (N_PORTS=2) -> output frame order 0,1,0,1, no byte interleaving, one bubble cycle between frames.
- Port 0 sends a 2000-byte frame with MAX_FRAME_BYTES=1518 -> beat 1518 has o_m_last=1 and o_m_user=1; the remaining 482 bytes are accepted with o_m_valid=0; o_trunc_count=1; the next grant goes to port 1 if it is requesting.
- Randomised i_m_ready (50%) and source valid gaps over 100 frames -> the output byte stream equals the per-port input streams concatenated in grant order; no beat is lost or duplicated.
- Reset asserted mid-frame at beat 20 -> next cycle o_m_valid=0, o_grant=0, o_trunc_count=0; after release, port 0 is granted first.
- 1-beat frame from port 1 carrying i_s_user=1 -> a single output beat with last=1 and user=1; o_trunc_count unchanged.

Source files
------------

// File: rtl/eth_tx_arbiter_if.sv
// Byte-wide AXI-stream bundle between N frame sources, the TX arbiter and the MAC.
// The slave modport is the arbiter's view; the master modport is the sources/MAC side.
interface eth_tx_arbiter_if #(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]   i_s_valid;
  logic [8*N_PORTS-1:0] i_s_data;
  logic [N_PORTS-1:0]   i_s_last;
  logic [N_PORTS-1:0]   i_s_user;
  logic [N_PORTS-1:0]   o_s_ready;
  logic                 o_m_valid;
  logic [7:0]           o_m_data;
  logic                 o_m_last;
  logic                 o_m_user;
  logic                 i_m_ready;

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_s_user, i_m_ready,
    output o_s_ready, o_m_valid, o_m_data, o_m_last, o_m_user
  );

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_s_user, i_m_ready,
    input  o_s_ready, o_m_valid, o_m_data, o_m_last, o_m_user
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide TX stream between
// N_PORTS frame sources. A winner owns the output until its tlast beat; a
// length watchdog cuts runaway frames and discards their remainder.
module eth_tx_arbiter #(
  parameter int N_PORTS         = 2,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic               i_clock,
  input  logic               i_reset,
  eth_tx_arbiter_if.slave    bus,
  output logic [N_PORTS-1:0] o_grant,
  output logic [15:0]        o_trunc_count
);
  localparam int          IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [15:0] WD_LIMIT = 16'(MAX_FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t             state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        trunc_q, trunc_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  logic               g_valid, g_last, g_user;
  logic [7:0]         g_data;
  logic               wd_hit;

  // Signals of the currently granted source
  assign g_valid = bus.i_s_valid[gidx_q];
  assign g_last  = bus.i_s_last[gidx_q];
  assign g_user  = bus.i_s_user[gidx_q];
  assign g_data  = bus.i_s_data[{gidx_q, 3'b000} +: 8];

  assign o_grant       = grant_q;
  assign o_trunc_count = trunc_q;

  // Round-robin search: first requesting port after the previous winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N_PORTS);
      if (!win_found && bus.i_s_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, passthrough muxing and watchdog
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    trunc_d       = trunc_q;
    wd_hit        = 1'b0;
    bus.o_s_ready = '0;
    bus.o_m_valid = 1'b0;
    bus.o_m_data  = g_data;
    bus.o_m_last  = 1'b0;
    bus.o_m_user  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = PASS;
        end
      end
      PASS: begin
        // The beat at MAX_FRAME_BYTES-1 without tlast becomes a forced error tlast
        wd_hit                = (cnt_q == WD_LIMIT) && !g_last;
        bus.o_m_valid         = g_valid;
        bus.o_s_ready[gidx_q] = bus.i_m_ready;
        bus.o_m_last          = g_last | wd_hit;
        bus.o_m_user          = g_user | wd_hit;
        if (g_valid && bus.i_m_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (wd_hit) begin
            if (trunc_q != 16'hFFFF) trunc_d = trunc_q + 16'd1;
            state_d = DROP;
          end else if (g_last) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        bus.o_s_ready[gidx_q] = 1'b1;
        if (g_valid && g_last) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
      cnt_q   <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter with two sources and a 1518-byte watchdog.
module tb_eth_tx_arbiter;
  localparam int NP   = 2;
  localparam int MAXB = 1518;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_tx_arbiter_if #(.N_PORTS(NP)) bus ();
  logic [NP-1:0] grant;
  logic [15:0]   trunc;

  eth_tx_arbiter #(.N_PORTS(NP), .MAX_FRAME_BYTES(MAXB)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .bus           (bus),
    .o_grant       (grant),
    .o_trunc_count (trunc)
  );

  int checks = 0;
  int errors = 0;

  // Source stimulus memories: beat = {data, last, user}
  logic [9:0] smem [NP][4096];
  int         shead [NP];
  int         stail [NP];
  int         gap_pct;
  bit         rand_ready;
  logic       ready_fix;

  // Outputs captured mid-cycle by step()
  logic          c_valid, c_last, c_user, c_xfer;
  logic [7:0]    c_data;
  logic [NP-1:0] c_grant, c_ready;
  logic [15:0]   c_trunc;

  function automatic logic [7:0] byte_of(int p, int f, int i);
    return 8'((p * 97 + f * 31 + i * 3 + 5) & 255);
  endfunction

  task automatic clr();
    for (int p = 0; p < NP; p++) begin
      shead[p] = 0;
      stail[p] = 0;
    end
  endtask

  task automatic push_frame(input int p, input int f, input int len, input bit ulast);
    for (int i = 0; i < len; i++) begin
      smem[p][stail[p]] = {byte_of(p, f, i), 1'(i == len - 1), 1'(ulast && (i == len - 1))};
      stail[p]++;
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, account handshakes at posedge
  task automatic step();
    logic [NP-1:0] acc;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (shead[p] < stail[p] && ($urandom_range(99) >= gap_pct)) begin
        bus.i_s_valid[p]       = 1'b1;
        bus.i_s_data[8*p +: 8] = smem[p][shead[p]][9:2];
        bus.i_s_last[p]        = smem[p][shead[p]][1];
        bus.i_s_user[p]        = smem[p][shead[p]][0];
      end else begin
        bus.i_s_valid[p]       = 1'b0;
        bus.i_s_data[8*p +: 8] = 8'h00;
        bus.i_s_last[p]        = 1'b0;
        bus.i_s_user[p]        = 1'b0;
      end
    end
    bus.i_m_ready = rand_ready ? 1'($urandom_range(1)) : ready_fix;
    #1;
    c_valid = bus.o_m_valid;
    c_data  = bus.o_m_data;
    c_last  = bus.o_m_last;
    c_user  = bus.o_m_user;
    c_ready = bus.o_s_ready;
    c_grant = grant;
    c_trunc = trunc;
    c_xfer  = bus.o_m_valid & bus.i_m_ready;
    acc     = bus.i_s_valid & bus.o_s_ready;
    @(posedge clk);
    for (int p = 0; p < NP; p++) if (acc[p]) shead[p]++;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", c_valid); end
    checks++;
    if (c_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", c_grant); end
    checks++;
    if (c_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", c_ready); end
    checks++;
    if (c_trunc !== 16'd0) begin errors++; $display("FAIL reset_trunc got %0d exp 0", c_trunc); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [14:0] exp, act;
    clr();
    push_frame(1, 0, 64, 1'b0);
    step();
    checks++;
    if ({c_valid, c_grant, c_ready} !== 5'b0) begin
      errors++; $display("FAIL single_bubble got v/g/r %b exp 0", {c_valid, c_grant, c_ready});
    end
    for (int i = 0; i < 64; i++) begin
      step();
      exp = {1'b1, byte_of(1, 0, i), 1'(i == 63), 1'b0, 2'b10, 2'b10};
      act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL single_beat%0d got %h exp %h", i, act, exp); end
    end
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL single_idle got %b exp 0", {c_valid, c_grant}); end
    checks++;
    if (c_trunc !== 16'd0) begin errors++; $display("FAIL single_trunc got %0d exp 0", c_trunc); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp, act;
    logic [1:0]  g;
    clr();
    push_frame(0, 1, 10, 1'b0);
    push_frame(0, 3, 10, 1'b0);
    push_frame(1, 2, 10, 1'b0);
    push_frame(1, 4, 10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      g = 2'(1 << (k % 2));
      step();
      checks++;
      if ({c_valid, c_grant, c_ready} !== 5'b0) begin
        errors++; $display("FAIL b2b_bubble%0d got v/g/r %b exp 0", k, {c_valid, c_grant, c_ready});
      end
      for (int i = 0; i < 10; i++) begin
        step();
        exp = {1'b1, byte_of(k % 2, k + 1, i), 1'(i == 9), 1'b0, g, g};
        act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
        checks++;
        if (act !== exp) begin errors++; $display("FAIL b2b_f%0d_beat%0d got %h exp %h", k, i, act, exp); end
      end
    end
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", {c_valid, c_grant}); end
  endtask

  task automatic test_truncation();
    logic [14:0] exp, act;
    int          bad;
    clr();
    push_frame(0, 10, 2000, 1'b0);
    push_frame(1, 11, 5, 1'b0);
    step();
    checks++;
    if ({c_valid, c_grant, c_ready} !== 5'b0) begin
      errors++; $display("FAIL trunc_bubble got v/g/r %b exp 0", {c_valid, c_grant, c_ready});
    end
    for (int i = 0; i < MAXB; i++) begin
      step();
      exp = {1'b1, byte_of(0, 10, i), 1'(i == MAXB - 1), 1'(i == MAXB - 1), 2'b01, 2'b01};
      act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL trunc_beat%0d got %h exp %h", i, act, exp); end
    end
    bad = 0;
    for (int i = 0; i < 2000 - MAXB; i++) begin
      step();
      if ({c_valid, c_grant, c_ready} !== 5'b0_01_01 && bad == 0) bad = i + 1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL trunc_drop at discard %0d got v/g/r %b exp 00101", bad - 1, {c_valid, c_grant, c_ready});
    end
    checks++;
    if (shead[0] != 2000) begin errors++; $display("FAIL trunc_consumed got %0d exp 2000", shead[0]); end
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL trunc_bubble2 got %b exp 0", {c_valid, c_grant}); end
    checks++;
    if (c_trunc !== 16'd1) begin errors++; $display("FAIL trunc_count got %0d exp 1", c_trunc); end
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {1'b1, byte_of(1, 11, i), 1'(i == 4), 1'b0, 2'b10, 2'b10};
      act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL trunc_next_beat%0d got %h exp %h", i, act, exp); end
    end
    step();
  endtask

  task automatic test_exact_max();
    logic [14:0] exp, act;
    clr();
    push_frame(1, 20, MAXB, 1'b0);
    step();
    for (int i = 0; i < MAXB; i++) begin
      step();
      exp = {1'b1, byte_of(1, 20, i), 1'(i == MAXB - 1), 1'b0, 2'b10, 2'b10};
      act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL exact_beat%0d got %h exp %h", i, act, exp); end
    end
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL exact_idle got %b exp 0", {c_valid, c_grant}); end
    checks++;
    if (c_trunc !== 16'd1) begin errors++; $display("FAIL exact_trunc got %0d exp 1", c_trunc); end
  endtask

  task automatic test_one_beat();
    logic [14:0] exp, act;
    clr();
    push_frame(1, 30, 1, 1'b1);
    step();
    step();
    exp = {1'b1, byte_of(1, 30, 0), 1'b1, 1'b1, 2'b10, 2'b10};
    act = {c_valid, c_data, c_last, c_user, c_grant, c_ready};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL one_beat got %h exp %h", act, exp); end
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL one_beat_idle got %b exp 0", {c_valid, c_grant}); end
    checks++;
    if (c_trunc !== 16'd1) begin errors++; $display("FAIL one_beat_trunc got %0d exp 1", c_trunc); end
  endtask

  task automatic test_random_stream();
    int  eptr [NP];
    int  g, cur, frames, cyc;
    bit  in_frame, done;
    clr();
    for (int k = 0; k < 100; k++)
      push_frame(int'($urandom_range(1)), 100 + k, int'($urandom_range(16, 1)), 1'b0);
    for (int p = 0; p < NP; p++) eptr[p] = 0;
    rand_ready = 1'b1;
    gap_pct    = 30;
    in_frame   = 1'b0;
    cur        = 0;
    frames     = 0;
    done       = 1'b0;
    cyc        = 0;
    while (!done && cyc < 20000) begin
      step();
      cyc++;
      if (c_xfer) begin
        g = (c_grant == 2'b01) ? 0 : (c_grant == 2'b10) ? 1 : -1;
        checks++;
        if (g < 0) begin
          errors++; $display("FAIL rand_grant got %b exp one-hot", c_grant);
        end else if (in_frame && g != cur) begin
          errors++; $display("FAIL rand_interleave got port %0d exp port %0d", g, cur);
        end else if ({c_data, c_last, c_user} !== smem[g][eptr[g]]) begin
          errors++; $display("FAIL rand_beat p%0d idx%0d got %h exp %h", g, eptr[g], {c_data, c_last, c_user}, smem[g][eptr[g]]);
        end
        if (g >= 0) begin
          eptr[g]++;
          cur      = g;
          in_frame = !c_last;
          if (c_last) frames++;
        end
      end
      done = (eptr[0] == stail[0]) && (eptr[1] == stail[1]);
    end
    rand_ready = 1'b0;
    gap_pct    = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL rand_timeout got %0d/%0d beats exp %0d/%0d", eptr[0], eptr[1], stail[0], stail[1]); end
    checks++;
    if (frames != 100) begin errors++; $display("FAIL rand_frames got %0d exp 100", frames); end
    checks++;
    if (shead[0] != stail[0] || shead[1] != stail[1]) begin
      errors++; $display("FAIL rand_consumed got %0d/%0d exp %0d/%0d", shead[0], shead[1], stail[0], stail[1]);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clr();
    push_frame(1, 40, 40, 1'b0);
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      step();
      if (c_xfer) n++;
    end
    checks++;
    if (n != 20) begin errors++; $display("FAIL midrst_progress got %0d beats exp 20", n); end
    rst = 1'b1;
    step();
    clr();
    step();
    checks++;
    if ({c_valid, c_grant, c_ready} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs got v/g/r %b exp 0", {c_valid, c_grant, c_ready});
    end
    checks++;
    if (c_trunc !== 16'd0) begin errors++; $display("FAIL midrst_trunc got %0d exp 0", c_trunc); end
    push_frame(0, 50, 3, 1'b0);
    push_frame(1, 51, 3, 1'b0);
    rst = 1'b0;
    step();
    checks++;
    if ({c_valid, c_grant} !== 3'b0) begin errors++; $display("FAIL midrst_bubble got %b exp 0", {c_valid, c_grant}); end
    step();
    checks++;
    if ({c_valid, c_grant, c_data} !== {1'b1, 2'b01, byte_of(0, 50, 0)}) begin
      errors++; $display("FAIL midrst_first_grant got %h exp %h", {c_valid, c_grant, c_data}, {1'b1, 2'b01, byte_of(0, 50, 0)});
    end
    n = 0;
    while (n < 50 && !(shead[0] == stail[0] && shead[1] == stail[1] && c_grant == 2'b00)) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midrst_drain got heads %0d/%0d exp 3/3", shead[0], shead[1]); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_s_valid = '0;
    bus.i_s_data  = '0;
    bus.i_s_last  = '0;
    bus.i_s_user  = '0;
    bus.i_m_ready = 1'b0;
    ready_fix     = 1'b1;
    rand_ready    = 1'b0;
    gap_pct       = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_truncation();
    test_exact_max();
    test_one_beat();
    test_random_stream();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
